// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: walks start/data/parity/stop using the companion edge/bit
// counter strobes, majority-votes three mid-bit samples, deserialises and flags errors.
module uart_rx_frame_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              edge_cnt_done,
  input  logic              bit_cnt_done,
  input  logic              sampling_timing,
  output logic              counter_en,
  output logic              deser_en,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [2:0]        vote;
  logic [DATA_W-1:0] shift;
  logic              par_en_q;
  logic              par_typ_q;
  logic              voted;

  assign voted      = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);
  assign counter_en = (state != IDLE);
  assign deser_en   = (state == DATA);

  // Three mid-bit samples; older ticks fall out so each bit votes on its own samples.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          vote <= 3'b000;
    else if (counter_en && sampling_timing) vote <= {vote[1:0], RX_IN};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      shift      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (!RX_IN) begin
          state     <= START;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          par_err   <= 1'b0;
          stp_err   <= 1'b0;
        end
        START: if (edge_cnt_done) state <= voted ? IDLE : DATA;
        DATA: if (edge_cnt_done) begin
          // LSB arrives first, so shifting right lands it in bit 0 after the last bit.
          shift <= {voted, shift[DATA_W-1:1]};
          if (bit_cnt_done) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: if (edge_cnt_done) begin
          if (voted != (^shift ^ par_typ_q)) par_err <= 1'b1;
          state <= STOP;
        end
        STOP: if (edge_cnt_done) begin
          if (!voted) stp_err <= 1'b1;
          else if (!par_err) begin
            P_DATA     <= shift;
            data_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the companion edge/bit counter, drives framed
// bytes (with optional sample glitches) and checks against a frame-level outcome model.
module tb_uart_rx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN, PAR_EN, PAR_TYP;
  logic       edge_cnt_done, bit_cnt_done, sampling_timing;
  logic       counter_en, deser_en, data_valid, par_err, stp_err;
  logic [7:0] P_DATA;

  uart_rx_frame_ctrl #(.DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .edge_cnt_done(edge_cnt_done), .bit_cnt_done(bit_cnt_done),
    .sampling_timing(sampling_timing), .counter_en(counter_en), .deser_en(deser_en),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  int prescale = 8;
  int edge_cnt = 0;
  int bit_cnt  = 0;
  int cyc      = 0;
  int tests    = 0;
  int fails    = 0;
  logic [7:0] exp_pdata = 8'h00;

  // Companion edge/bit counter behaviour
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!counter_en)                 edge_cnt <= 0;
    else if (edge_cnt == prescale-1) edge_cnt <= 0;
    else                             edge_cnt <= edge_cnt + 1;
    if (!deser_en)          bit_cnt <= 0;
    else if (edge_cnt_done) bit_cnt <= bit_cnt + 1;
  end
  assign edge_cnt_done   = counter_en && (edge_cnt == prescale-1);
  assign sampling_timing = counter_en && (edge_cnt >= prescale/2-1) && (edge_cnt <= prescale/2+1);
  assign bit_cnt_done    = deser_en && (bit_cnt == 7);

  int         dv_cyc_q[$];
  logic [7:0] dv_dat_q[$];
  always @(negedge CLK) if (data_valid === 1'b1) begin
    dv_cyc_q.push_back(cyc);
    dv_dat_q.push_back(P_DATA);
  end

  // Frame outcome from the line-level rules: {valid, par_err, stp_err}
  function automatic logic [2:0] model(input logic [7:0] d, input logic pen, ptyp, pbit, stop);
    logic perr;
    perr = pen && ((($countones(d) + pbit) % 2) != ptyp);
    return {(!perr && stop), perr, !stop};
  endfunction

  function automatic logic good_par(input logic [7:0] d, input logic ptyp);
    return logic'(($countones(d) + ptyp) % 2);
  endfunction

  task automatic drive_bit(input logic b, input bit noisy, input int gsel);
    int   tick;
    logic inv;
    tick = 0;
    for (int k = 0; k < prescale; k++) begin
      inv = 1'b0;
      if (noisy) begin
        if (sampling_timing) begin inv = (tick == gsel); tick++; end
        else inv = ($urandom_range(3) == 0);
      end
      RX_IN = b ^ inv;
      @(posedge CLK); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, ptyp, pbit, stop,
                            input bit noisy, output int c0, output int nbits);
    PAR_EN = pen; PAR_TYP = ptyp; c0 = cyc;
    nbits = pen ? 11 : 10;
    drive_bit(1'b0, 0, 0);
    PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(d[i], noisy, int'($urandom_range(2)));
    if (pen) drive_bit(pbit, 0, 0);
    drive_bit(stop, 0, 0);
    RX_IN = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic test_reset;
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    idle(3);
    tests++; if (counter_en !== 1'b0) begin fails++; $display("FAIL reset_counter_en got %b exp 0", counter_en); end
    tests++; if (deser_en !== 1'b0) begin fails++; $display("FAIL reset_deser_en got %b exp 0", deser_en); end
    tests++; if (P_DATA !== 8'h00) begin fails++; $display("FAIL reset_p_data got %h exp 00", P_DATA); end
    tests++; if ({data_valid, par_err, stp_err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {data_valid, par_err, stp_err}); end
    RST = 1'b1;
    idle(4);
    tests++; if (counter_en !== 1'b0) begin fails++; $display("FAIL idle_counter_en got %b exp 0", counter_en); end
  endtask

  task automatic test_parity_ok;
    int c0, nb, n0;
    prescale = 8; n0 = dv_cyc_q.size();
    send_frame(8'hA5, 1, 0, 0, 1, 0, c0, nb); idle(3); exp_pdata = 8'hA5;
    tests++; if (dv_cyc_q.size() - n0 != 1) begin fails++; $display("FAIL par_ok_pulses got %0d exp 1", dv_cyc_q.size() - n0); end
    else begin
      tests++; if (dv_cyc_q[n0] != c0 + nb*prescale + 1) begin fails++; $display("FAIL par_ok_pulse_cyc got %0d exp %0d", dv_cyc_q[n0], c0 + nb*prescale + 1); end
    end
    tests++; if (P_DATA !== exp_pdata) begin fails++; $display("FAIL par_ok_data got %h exp %h", P_DATA, exp_pdata); end
    tests++; if ({par_err, stp_err} !== 2'b00) begin fails++; $display("FAIL par_ok_errs got %b exp 00", {par_err, stp_err}); end
  endtask

  task automatic test_parity_err;
    int c0, nb, n0;
    prescale = 8; n0 = dv_cyc_q.size();
    send_frame(8'hA5, 1, 0, 1, 1, 0, c0, nb); idle(3);
    tests++; if (dv_cyc_q.size() != n0) begin fails++; $display("FAIL par_err_pulses got %0d exp 0", dv_cyc_q.size() - n0); end
    tests++; if (P_DATA !== exp_pdata) begin fails++; $display("FAIL par_err_data got %h exp %h", P_DATA, exp_pdata); end
    tests++; if ({par_err, stp_err} !== 2'b10) begin fails++; $display("FAIL par_err_errs got %b exp 10", {par_err, stp_err}); end
  endtask

  task automatic test_stop_err;
    int c0, nb, n0;
    prescale = 16; n0 = dv_cyc_q.size();
    send_frame(8'h3C, 0, 0, 0, 0, 0, c0, nb); idle(3);
    tests++; if (dv_cyc_q.size() != n0) begin fails++; $display("FAIL stp_err_pulses got %0d exp 0", dv_cyc_q.size() - n0); end
    tests++; if ({par_err, stp_err} !== 2'b01) begin fails++; $display("FAIL stp_err_errs got %b exp 01", {par_err, stp_err}); end
    tests++; if (P_DATA !== exp_pdata) begin fails++; $display("FAIL stp_err_data got %h exp %h", P_DATA, exp_pdata); end
    n0 = dv_cyc_q.size();
    send_frame(8'hC3, 0, 0, 0, 1, 0, c0, nb); idle(3); exp_pdata = 8'hC3;
    tests++; if (dv_cyc_q.size() - n0 != 1) begin fails++; $display("FAIL stp_clr_pulses got %0d exp 1", dv_cyc_q.size() - n0); end
    tests++; if ({P_DATA, par_err, stp_err} !== {exp_pdata, 2'b00}) begin fails++; $display("FAIL stp_clr_result got %h/%b exp %h/00", P_DATA, {par_err, stp_err}, exp_pdata); end
  endtask

  task automatic test_start_glitch;
    int c0, n0;
    prescale = 16; n0 = dv_cyc_q.size(); c0 = cyc;
    RX_IN = 1'b0; idle(2); RX_IN = 1'b1;
    while (cyc < c0 + prescale) idle(1);
    tests++; if ({counter_en, deser_en} !== 2'b10) begin fails++; $display("FAIL glitch_in_start got %b exp 10", {counter_en, deser_en}); end
    idle(1);
    tests++; if (counter_en !== 1'b0) begin fails++; $display("FAIL glitch_back_idle got %b exp 0", counter_en); end
    idle(prescale);
    tests++; if (dv_cyc_q.size() != n0 || {par_err, stp_err} !== 2'b00) begin fails++; $display("FAIL glitch_no_pulse got %0d/%b exp 0/00", dv_cyc_q.size() - n0, {par_err, stp_err}); end
  endtask

  task automatic test_vote_glitch;
    int c0, nb, n0;
    for (int p = 0; p < 2; p++) begin
      prescale = p ? 16 : 8; n0 = dv_cyc_q.size();
      send_frame(8'h5A, 0, 0, 0, 1, 1, c0, nb); idle(3); exp_pdata = 8'h5A;
      tests++; if (dv_cyc_q.size() - n0 != 1 || P_DATA !== exp_pdata) begin fails++; $display("FAIL vote_glitch_p%0d got %0d/%h exp 1/%h", prescale, dv_cyc_q.size() - n0, P_DATA, exp_pdata); end
    end
  endtask

  task automatic test_back_to_back;
    int c0a, c0b, nb, n0;
    logic [7:0] a, b;
    prescale = 16; n0 = dv_cyc_q.size();
    a = 8'($urandom); b = 8'($urandom);
    send_frame(a, 0, 0, 0, 1, 0, c0a, nb);
    send_frame(b, 0, 0, 0, 1, 0, c0b, nb); idle(3); exp_pdata = b;
    tests++; if (dv_cyc_q.size() - n0 != 2) begin fails++; $display("FAIL b2b_pulses got %0d exp 2", dv_cyc_q.size() - n0); end
    else begin
      tests++; if (dv_dat_q[n0] !== a || dv_dat_q[n0+1] !== b) begin fails++; $display("FAIL b2b_data got %h,%h exp %h,%h", dv_dat_q[n0], dv_dat_q[n0+1], a, b); end
      // the second start is seen one cycle late because of the single IDLE cycle
      tests++; if (dv_cyc_q[n0+1] != c0b + nb*prescale + 2) begin fails++; $display("FAIL b2b_cyc got %0d exp %0d", dv_cyc_q[n0+1], c0b + nb*prescale + 2); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int c0, nb, n0;
    prescale = 8; PAR_EN = 1'b0;
    drive_bit(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0, 0);
    RX_IN = 1'b1; idle(3);
    tests++; if (deser_en !== 1'b1) begin fails++; $display("FAIL rst_mid_in_data got %b exp 1", deser_en); end
    #2 RST = 1'b0; #1;
    exp_pdata = 8'h00; n0 = dv_cyc_q.size();
    tests++; if ({counter_en, deser_en, data_valid, par_err, stp_err, P_DATA} !== 13'h0) begin fails++; $display("FAIL rst_mid_outputs got %b/%h exp 00000/00", {counter_en, deser_en, data_valid, par_err, stp_err}, P_DATA); end
    idle(2); RST = 1'b1; idle(3*prescale);
    tests++; if (dv_cyc_q.size() != n0 || counter_en !== 1'b0) begin fails++; $display("FAIL rst_mid_quiet got %0d/%b exp 0/0", dv_cyc_q.size() - n0, counter_en); end
    send_frame(8'h81, 0, 0, 0, 1, 0, c0, nb); idle(3); exp_pdata = 8'h81;
    tests++; if (dv_cyc_q.size() - n0 != 1 || P_DATA !== exp_pdata) begin fails++; $display("FAIL rst_mid_recover got %0d/%h exp 1/%h", dv_cyc_q.size() - n0, P_DATA, exp_pdata); end
  endtask

  task automatic test_random;
    int c0, nb, n0, expn;
    logic [7:0] d;
    logic pen, ptyp, pbit, stop;
    logic [2:0] m;
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(2)) 0: prescale = 8; 1: prescale = 16; default: prescale = 32; endcase
      d = 8'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
      pbit = good_par(d, ptyp) ^ ($urandom_range(4) == 0);
      stop = ($urandom_range(4) != 0);
      m = model(d, pen, ptyp, pbit, stop);
      n0 = dv_cyc_q.size();
      send_frame(d, pen, ptyp, pbit, stop, 1'($urandom), c0, nb);
      idle(3 + int'($urandom_range(3)));
      if (m[2]) exp_pdata = d;
      expn = m[2] ? 1 : 0;
      tests++; if (dv_cyc_q.size() - n0 != expn) begin fails++; $display("FAIL rand%0d_pulses got %0d exp %0d", it, dv_cyc_q.size() - n0, expn); end
      else if (expn == 1) begin
        tests++; if (dv_dat_q[n0] !== d || dv_cyc_q[n0] != c0 + nb*prescale + 1) begin fails++; $display("FAIL rand%0d_pulse got %h@%0d exp %h@%0d", it, dv_dat_q[n0], dv_cyc_q[n0], d, c0 + nb*prescale + 1); end
      end
      tests++; if (P_DATA !== exp_pdata) begin fails++; $display("FAIL rand%0d_data got %h exp %h", it, P_DATA, exp_pdata); end
      tests++; if ({par_err, stp_err} !== m[1:0]) begin fails++; $display("FAIL rand%0d_errs got %b exp %b", it, {par_err, stp_err}, m[1:0]); end
    end
  endtask

  initial begin
    test_reset;
    test_parity_ok;
    test_parity_err;
    test_stop_err;
    test_start_glitch;
    test_vote_glitch;
    test_back_to_back;
    test_reset_mid_frame;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
